// File: rtl/pingpong_pkg.sv
// pingpong_pkg: shared bank index type, bank state constants and index-width helper.
package pingpong_pkg;
    typedef logic bank_t;
    localparam logic BANK_EMPTY = 1'b0;
    localparam logic BANK_FULL = 1'b1;
    function automatic int clog2(input int n);
        int r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction
endpackage

// File: rtl/pingpong_bank_ctrl_if.sv
// pingpong_bank_ctrl_if: producer and consumer valid/ready handshakes of the ping-pong buffer.
interface pingpong_bank_ctrl_if #(parameter int DATA_W = 8);
    logic in_valid, in_ready, out_valid, out_ready, out_last;
    logic [DATA_W-1:0] in_data, out_data;
    modport master(output in_valid, in_data, out_ready, input in_ready, out_valid, out_data, out_last);
    modport slave(input in_valid, in_data, out_ready, output in_ready, out_valid, out_data, out_last);
endinterface

// File: rtl/bank_sel_dec1to2.sv
// bank_sel_dec1to2: one-hot bank enable decode of the write bank select.
module bank_sel_dec1to2
    import pingpong_pkg::*;
(
    input bank_t sel,
    output logic [1:0] en
);
    assign en = (sel == 1'b0) ? 2'b01 : (sel == 1'b1) ? 2'b10 : 2'b00;
endmodule

// File: rtl/pingpong_bank_ctrl.sv
// pingpong_bank_ctrl: two-bank ping-pong word buffer; fills one bank while the other drains.
// Defining PINGPONG_FLUSH_EN adds a flush port that commits a partially written bank.
module pingpong_bank_ctrl
    import pingpong_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH = 4
) (
    input logic clk,
    input logic rst,
    pingpong_bank_ctrl_if.slave bus,
`ifdef PINGPONG_FLUSH_EN
    input logic flush,
`endif
    output bank_t wr_bank,
    output logic [1:0] wr_bank_en,
    output bank_t rd_bank,
    output logic [1:0] bank_full
);
    localparam int IW = clog2(DEPTH);
    logic [DATA_W-1:0] mem [2][DEPTH];
    logic [IW-1:0] wr_idx, rd_idx;
    logic [IW:0] len_rd;
    logic wr_hs, rd_hs, commit;
    assign bus.in_ready = bank_full[wr_bank] == BANK_EMPTY;
    assign bus.out_valid = bank_full[rd_bank] == BANK_FULL;
    assign bus.out_data = mem[rd_bank][rd_idx];
    assign bus.out_last = bus.out_valid && rd_idx == IW'(len_rd - 1'b1);
    assign wr_hs = bus.in_valid && bus.in_ready;
    assign rd_hs = bus.out_valid && bus.out_ready;
`ifdef PINGPONG_FLUSH_EN
    logic [IW:0] len [2];
    // a flush only commits when the bank holds at least one word, counting this cycle's write
    assign commit = (wr_hs && wr_idx == IW'(DEPTH - 1)) || (flush && (wr_idx != '0 || wr_hs));
    assign len_rd = len[rd_bank];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) len <= '{default: (IW + 1)'(DEPTH)};
        else if (commit) len[wr_bank] <= (IW + 1)'(wr_idx) + (IW + 1)'(wr_hs);
    end
`else
    assign commit = wr_hs && wr_idx == IW'(DEPTH - 1);
    assign len_rd = (IW + 1)'(DEPTH);
`endif
    always_ff @(posedge clk) begin
        if (wr_hs) mem[wr_bank][wr_idx] <= bus.in_data;
    end
    // commit and drain always target different banks, so both flag updates can land together
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            wr_idx <= '0;
            rd_idx <= '0;
            bank_full <= {BANK_EMPTY, BANK_EMPTY};
        end else begin
            if (wr_hs) wr_idx <= wr_idx + 1'b1;
            if (commit) begin
                bank_full[wr_bank] <= BANK_FULL;
                wr_bank <= ~wr_bank;
                wr_idx <= '0;
            end
            if (rd_hs) begin
                rd_idx <= rd_idx + 1'b1;
                if (bus.out_last) begin
                    bank_full[rd_bank] <= BANK_EMPTY;
                    rd_bank <= ~rd_bank;
                    rd_idx <= '0;
                end
            end
        end
    end
    bank_sel_dec1to2 u_dec (.sel(wr_bank), .en(wr_bank_en));
endmodule
